// File: rtl/change_dispenser.sv
// Coin-return engine: runs the inactivity timeout and pays the balance back
// as a greedy stream of one-hot coin pulses, one coin per cycle.
module change_dispenser #(
    parameter int kNumCoins   = 3,
    parameter int kTotalBits  = 31,
    parameter int kWaitCycles = 100,
    parameter int COIN0       = 100,
    parameter int COIN1       = 500,
    parameter int COIN2       = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_activity,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] i_balance,
    output logic [kNumCoins-1:0]  o_return_coin,
    output logic [kTotalBits-1:0] o_return_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_residue,
    output logic [31:0]           o_wait_time
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPENSE,
        S_DONE
    } state_t;

    localparam logic [kTotalBits-1:0] kCoinVal [3] = '{
        kTotalBits'(COIN0), kTotalBits'(COIN1), kTotalBits'(COIN2)
    };
    localparam logic [31:0] kWaitLoad = 32'(kWaitCycles);

    state_t                  state_q, state_d;
    logic [kTotalBits-1:0]   remaining_q, remaining_d;
    logic [kNumCoins-1:0]    coin_q, coin_d;
    logic [kTotalBits-1:0]   value_q, value_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [kTotalBits-1:0]   residue_q, residue_d;
    logic [31:0]             wait_q, wait_d;

    logic [kTotalBits-1:0]   pick_val;
    logic [kNumCoins-1:0]    pick_oh;
    logic [kTotalBits-1:0]   new_rem;
    logic                    bal_nz;

    assign bal_nz = (i_balance != '0);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        coin_d      = '0;
        value_d     = '0;
        done_d      = 1'b0;
        residue_d   = residue_q;
        wait_d      = wait_q;
        pick_val    = '0;
        pick_oh     = '0;

        // Ascending scan: the last fitting denomination is the largest one.
        for (int i = 0; i < 3; i++) begin
            if (kCoinVal[i] <= remaining_q) begin
                pick_val   = kCoinVal[i];
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
            end
        end
        new_rem = remaining_q - pick_val;

        case (state_q)
            S_IDLE: begin
                if (i_trigger_return && bal_nz) begin
                    remaining_d = i_balance;
                    state_d     = S_DISPENSE;
                end else if (i_activity) begin
                    wait_d = kWaitLoad;
                end else if ((wait_q == '0) && bal_nz) begin
                    remaining_d = i_balance;
                    state_d     = S_DISPENSE;
                end else if (bal_nz) begin
                    wait_d = wait_q - 32'd1;
                end
            end
            S_DISPENSE: begin
                if (remaining_q < kCoinVal[0]) begin
                    residue_d = remaining_q;
                    state_d   = S_DONE;
                end else begin
                    coin_d      = pick_oh;
                    value_d     = pick_val;
                    remaining_d = new_rem;
                    if (new_rem < kCoinVal[0]) begin
                        residue_d = new_rem;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                wait_d  = kWaitLoad;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DISPENSE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            coin_q      <= '0;
            value_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            residue_q   <= '0;
            wait_q      <= kWaitLoad;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            coin_q      <= coin_d;
            value_q     <= value_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            residue_q   <= residue_d;
            wait_q      <= wait_d;
        end
    end

    assign o_return_coin  = coin_q;
    assign o_return_value = value_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_residue      = residue_q;
    assign o_wait_time    = wait_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a per-cycle expectation model built from greedy
// division plus directed runs with hand-computed literal values.
module tb_change_dispenser;

    localparam int KW = 5;

    logic        clk;
    logic        reset;
    logic        act;
    logic        trig;
    logic [30:0] bal;
    logic [2:0]  o_return_coin;
    logic [30:0] o_return_value;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residue;
    logic [31:0] o_wait_time;

    change_dispenser #(
        .kNumCoins(3), .kTotalBits(31), .kWaitCycles(KW),
        .COIN0(100), .COIN1(500), .COIN2(1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_activity(act),
        .i_trigger_return(trig),
        .i_balance(bal),
        .o_return_coin(o_return_coin),
        .o_return_value(o_return_value),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_residue(o_residue),
        .o_wait_time(o_wait_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Expected outputs after each edge.
    typedef struct {
        logic [2:0]  coin;
        logic [30:0] value;
        logic        busy;
        logic        done;
        logic [30:0] residue;
        logic [31:0] wait_t;
    } exp_t;

    function automatic exp_t mk(input logic [2:0] c, input int v, input logic b,
                                input logic d, input int r, input int w);
        exp_t e;
        e.coin = c; e.value = 31'(v); e.busy = b; e.done = d;
        e.residue = 31'(r); e.wait_t = 32'(w);
        return e;
    endfunction

    exp_t plan_q[$];
    exp_t exp_now;
    int   m_wait = KW;
    int   m_res  = 0;
    bit   model_valid = 0;

    // Whole run planned up front: entry cycle, one cycle per coin, done cycle.
    task automatic build_plan(input int b);
        int vals[3];
        int cnt[3];
        int rem, k, j;
        vals = '{100, 500, 1000};
        rem = b;
        k = 0;
        for (int i = 2; i >= 0; i--) begin
            cnt[i] = rem / vals[i];
            rem    = rem % vals[i];
            k     += cnt[i];
        end
        plan_q.push_back(mk(3'b000, 0, 1'b1, 1'b0, m_res, m_wait));
        if (k == 0) begin
            plan_q.push_back(mk(3'b000, 0, 1'b0, 1'b0, rem, m_wait));
        end else begin
            j = 0;
            for (int i = 2; i >= 0; i--) begin
                for (int c = 0; c < cnt[i]; c++) begin
                    plan_q.push_back(mk(3'(1 << i), vals[i], (j != k - 1), 1'b0,
                                        (j == k - 1) ? rem : m_res, m_wait));
                    j++;
                end
            end
        end
        plan_q.push_back(mk(3'b000, 0, 1'b0, 1'b1, rem, KW));
    endtask

    always @(posedge clk) begin
        bit start;
        start = 0;
        if (reset) begin
            plan_q.delete();
            exp_now = mk(3'b000, 0, 1'b0, 1'b0, 0, KW);
            model_valid = 1;
        end else if (plan_q.size() > 0) begin
            exp_now = plan_q.pop_front();
        end else begin
            if (trig && bal != 0)            start = 1;
            else if (act)                    m_wait = KW;
            else if (m_wait == 0 && bal != 0) start = 1;
            else if (bal != 0)               m_wait = m_wait - 1;
            if (start) begin
                build_plan(int'(bal));
                exp_now = plan_q.pop_front();
            end else begin
                exp_now = mk(3'b000, 0, 1'b0, 1'b0, m_res, m_wait);
            end
        end
        m_wait = int'(exp_now.wait_t);
        m_res  = int'(exp_now.residue);
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model coin",    32'(o_return_coin),  32'(exp_now.coin));
            check("model value",   32'(o_return_value), 32'(exp_now.value));
            check("model busy",    32'(o_busy),         32'(exp_now.busy));
            check("model done",    32'(o_done),         32'(exp_now.done));
            check("model residue", 32'(o_residue),      32'(exp_now.residue));
            check("model wait",    o_wait_time,         exp_now.wait_t);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check(name, 32'(o_done), 32'd1);
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int tbl_bal[5];
        int tbl_res[5];
        tbl_bal = '{3100, 600, 99, 1750, 2600};
        tbl_res = '{0, 0, 99, 50, 0};

        reset = 1'b1; act = 1'b0; trig = 1'b0; bal = '0;
        repeat (2) tick();
        check("reset wait", o_wait_time, 32'd5);
        check("reset coin", 32'(o_return_coin), 32'd0);
        check("reset residue", 32'(o_residue), 32'd0);
        reset = 1'b0;
        tick();

        // 1600: 1000, 500, 100 then done.
        bal = 31'd1600; trig = 1'b1; tick();
        trig = 1'b0; bal = '0;
        check("1600 busy entry", 32'(o_busy), 32'd1);
        tick(); check("1600 coin1", 32'(o_return_coin), 32'b100);
        check("1600 val1", 32'(o_return_value), 32'd1000);
        tick(); check("1600 coin2", 32'(o_return_coin), 32'b010);
        check("1600 val2", 32'(o_return_value), 32'd500);
        tick(); check("1600 coin3", 32'(o_return_coin), 32'b001);
        check("1600 val3", 32'(o_return_value), 32'd100);
        tick(); check("1600 done", 32'(o_done), 32'd1);
        check("1600 residue", 32'(o_residue), 32'd0);
        tick();

        // 2000: two 1000 coins, busy for exactly two cycles.
        bal = 31'd2000; trig = 1'b1; tick();
        trig = 1'b0; bal = '0;
        check("2000 busy c0", 32'(o_busy), 32'd1);
        tick(); check("2000 coin1", 32'(o_return_coin), 32'b100);
        check("2000 busy c1", 32'(o_busy), 32'd1);
        tick(); check("2000 coin2", 32'(o_return_coin), 32'b100);
        check("2000 busy c2", 32'(o_busy), 32'd0);
        tick(); check("2000 done", 32'(o_done), 32'd1);
        tick();

        // 150: one coin, residue 50.
        bal = 31'd150; trig = 1'b1; tick();
        trig = 1'b0; bal = '0;
        tick(); check("150 val", 32'(o_return_value), 32'd100);
        tick(); check("150 done", 32'(o_done), 32'd1);
        check("150 residue", 32'(o_residue), 32'd50);
        tick();

        // 50: no coin at all.
        bal = 31'd50; trig = 1'b1; tick();
        trig = 1'b0; bal = '0;
        tick(); check("50 no coin", 32'(o_return_coin), 32'd0);
        check("50 residue", 32'(o_residue), 32'd50);
        tick(); check("50 done", 32'(o_done), 32'd1);
        check("50 wait reload", o_wait_time, 32'd5);

        // Timeout with an activity reload at wait_time 2.
        bal = 31'd500;
        tick(); check("to wait4", o_wait_time, 32'd4);
        tick(); tick(); check("to wait2", o_wait_time, 32'd2);
        act = 1'b1; tick(); act = 1'b0;
        check("to reload", o_wait_time, 32'd5);
        for (int w = 4; w >= 0; w--) begin
            tick();
            check("to count", o_wait_time, 32'(w));
        end
        check("to idle at zero", 32'(o_busy), 32'd0);
        tick(); check("to start", 32'(o_busy), 32'd1);
        bal = '0;
        tick(); check("to coin", 32'(o_return_coin), 32'b010);
        tick(); check("to done", 32'(o_done), 32'd1);
        tick();

        // Trigger with zero balance is ignored.
        trig = 1'b1; tick(); trig = 1'b0;
        check("zero trig busy", 32'(o_busy), 32'd0);
        tick(); check("zero trig coin", 32'(o_return_coin), 32'd0);

        // Trigger wins over simultaneous activity.
        bal = 31'd100; trig = 1'b1; act = 1'b1; tick();
        trig = 1'b0; act = 1'b0; bal = '0;
        check("trig+act busy", 32'(o_busy), 32'd1);
        tick(); check("trig+act coin", 32'(o_return_coin), 32'b001);
        tick(); check("trig+act done", 32'(o_done), 32'd1);
        tick();

        // Reset in the second DISPENSE cycle of a 1600 run.
        bal = 31'd1600; trig = 1'b1; tick();
        trig = 1'b0; bal = '0;
        tick(); check("rst run coin1", 32'(o_return_coin), 32'b100);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst coin", 32'(o_return_coin), 32'd0);
        check("rst value", 32'(o_return_value), 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst wait", o_wait_time, 32'd5);
        repeat (4) begin
            tick();
            check("rst no coin", 32'(o_return_coin), 32'd0);
            check("rst no done", 32'(o_done), 32'd0);
        end

        // Further balances checked against the model plus literal residues.
        for (int t = 0; t < 5; t++) begin
            bal = 31'(tbl_bal[t]); trig = 1'b1; tick();
            trig = 1'b0; bal = '0;
            wait_done("tbl done");
            check("tbl residue", 32'(o_residue), 32'(tbl_res[t]));
            tick();
        end

        repeat (3) tick();
        summary();
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return engine for the vending machine: the outbound counterpart to the coin-input path. It watches the customer balance, runs the inactivity timeout, and on timeout or an explicit return request emits the balance back as a greedy sequence of one-hot `o_return_coin` pulses, one coin per cycle. The state calculator consumes these pulses and adds `coin_value[i]` to `return_total` for each asserted bit.

## Interface
Parameters:
- `kNumCoins`, 3: number of coin denominations.
- `kTotalBits`, 31: width of balance and value paths.
- `kWaitCycles`, 100: inactivity timeout in cycles.
- `COIN0`/`COIN1`/`COIN2`, 100/500/1000: coin values, strictly ascending by index.

Ports (clock is `clk`; reset is `reset`, synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous active-high reset.
- `i_activity`  in  1  coin inserted or item selected this cycle; restarts the timeout.
- `i_trigger_return`  in  1  customer return request.
- `i_balance`  in  kTotalBits  current balance (input − output − return totals).
- `o_return_coin`  out  kNumCoins  one-hot coin emitted this cycle, or 0.
- `o_return_value`  out  kTotalBits  value of the coin in `o_return_coin`, or 0.
- `o_busy`  out  1  high while in DISPENSE.
- `o_done`  out  1  one-cycle pulse when dispensing ends.
- `o_residue`  out  kTotalBits  undispensable remainder from the last run.
- `o_wait_time`  out  32  remaining timeout cycles.

## Operation
- All outputs are registered.
- Reset values: `o_return_coin`=0, `o_return_value`=0, `o_busy`=0, `o_done`=0, `o_residue`=0, `o_wait_time`=kWaitCycles, state IDLE, internal `remaining`=0.
- States: IDLE, DISPENSE, DONE.
- IDLE, with priorities evaluated in this order:
  1. `i_trigger_return` && `i_balance`≠0: latch `remaining`=`i_balance` and go to DISPENSE.
  2. `i_activity`: reload `o_wait_time`=kWaitCycles.
  3. `o_wait_time`==0 && `i_balance`≠0: latch the balance and go to DISPENSE (timeout).
  4. `i_balance`≠0: decrement `o_wait_time`.
  5. `i_balance`==0: hold `o_wait_time`.
  - A trigger with zero balance is a no-op.
- DISPENSE (`o_busy`=1), each cycle:
  - Select the highest index i with COINi ≤ `remaining`.
  - Drive `o_return_coin`=1<<i and `o_return_value`=COINi.
  - Update `remaining` -= COINi.
  - If the new `remaining`==0, or is < COIN0, set `o_residue`=new `remaining` and go to DONE.
  - If `remaining` < COIN0 on entry, emit no coin, set `o_residue`=`remaining`, and go to DONE.
  - `i_activity`, `i_trigger_return`, and `i_balance` changes are ignored during DISPENSE.
- DONE:
  - `o_done`=1 and `o_return_coin`=0 for exactly one cycle.
  - Reload `o_wait_time`=kWaitCycles and return to IDLE.
- Arithmetic is unsigned kTotalBits. `remaining` never underflows because a coin is only chosen when COINi ≤ `remaining`.
- `o_residue` holds until the next run completes or reset.

## Timing
- Trigger sampled at edge N: the first coin is visible after edge N+1. A balance of k coins produces pulses in cycles N+1..N+k, and `o_done` in cycle N+k+1.
- Timeout: with no activity and a nonzero balance, DISPENSE is entered kWaitCycles+1 edges after the last reload.
- `o_return_coin` is never multi-hot and is 0 outside DISPENSE.
- `reset` mid-DISPENSE: the next edge clears all state to reset values. The remaining coins are not emitted and no `o_done` pulse occurs.
- Simultaneous `i_activity` and an expired timer in IDLE: the timer reloads and no dispense starts.

## Test plan
- Reset, then `i_balance`=1600 with a trigger pulse → `o_return_coin` 100, 010, 001 in three consecutive cycles; `o_return_value` 1000, 500, 100; `o_done` pulse next cycle; `o_residue`=0.
- `i_balance`=2000 with trigger → `o_return_coin`=100 twice, then `o_done`; `o_busy` high for exactly 2 cycles.
- `i_balance`=150 with trigger → one coin (value 100), then `o_done` with `o_residue`=50. `i_balance`=50 with trigger → no coin, `o_done` one cycle after DISPENSE entry, `o_residue`=50.
- kWaitCycles=5, `i_balance`=500, no activity → `o_wait_time` counts 5..0 and dispensing starts the following edge. An `i_activity` pulse at `o_wait_time`=2 reloads the counter to 5.
- Trigger with `i_balance`=0 → no state change and `o_return_coin` stays 0. Trigger and `i_activity` together with balance 100 → dispense starts (trigger wins).
- `reset` asserted in the second DISPENSE cycle of a 1600 run → all outputs return to reset values next edge, no further coins, no `o_done`.
